// File: rtl/maxpool2d_2x2_stride2.sv
// rtl/maxpool2d_2x2_stride2.sv - 2x2 stride-2 max pooling over a raster stream of packed fp32 channels
//
// Consumes one pixel per Valid_In beat in row-major order and emits one pooled
// pixel for every 2x2 window. Each window is built from two pair-maxima:
// the pair from the even row is parked in a line buffer. The pair from the odd
// row is then combined with it to produce the output, registered on the same edge.
//
// Ports:
//   clk        - single clock, all state on rising edge
//   rst        - asynchronous active-low reset
//   Data_In    - CHANNELS words of DATA_WIDHT bits, channel 0 in the LSBs
//   Valid_In   - Data_In carries one pixel this cycle
//   Data_Out   - pooled pixel, same packing; holds while Valid_Out is low
//   Valid_Out  - one-cycle pulse per pooled pixel
//   Frame_Done - pulses together with the last pooled pixel of a frame

module maxpool2d_2x2_stride2 #(
    parameter int DATA_WIDHT = 32,
    parameter int CHANNELS   = 8,
    parameter int IN_WIDTH   = 218,
    parameter int IN_HEIGHT  = 218
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_WIDHT*CHANNELS-1:0] Data_In,
    input  logic                           Valid_In,
    output logic [DATA_WIDHT*CHANNELS-1:0] Data_Out,
    output logic                           Valid_Out,
    output logic                           Frame_Done
);

    localparam int BUS_W  = DATA_WIDHT * CHANNELS;
    localparam int OUT_W  = IN_WIDTH / 2;
    localparam int OUT_H  = IN_HEIGHT / 2;
    localparam int COL_W  = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam int ROW_W  = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
    localparam int ADDR_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    // IEEE-754 max on raw bit patterns. Mapping each word to an unsigned key
    // (flip everything for negatives, set the sign bit for positives) makes
    // value order equal unsigned key order. +0/-0 map to different keys, so
    // they are special-cased as equal. Ties keep the earlier operand a.
    function automatic logic [DATA_WIDHT-1:0] fmax(
        input logic [DATA_WIDHT-1:0] a,
        input logic [DATA_WIDHT-1:0] b
    );
        logic [DATA_WIDHT-1:0] ka;
        logic [DATA_WIDHT-1:0] kb;
        logic                  both_zero;
        ka = a[DATA_WIDHT-1] ? ~a : (a | {1'b1, {(DATA_WIDHT-1){1'b0}}});
        kb = b[DATA_WIDHT-1] ? ~b : (b | {1'b1, {(DATA_WIDHT-1){1'b0}}});
        both_zero = (a[DATA_WIDHT-2:0] == '0) && (b[DATA_WIDHT-2:0] == '0);
        if (!both_zero && (kb > ka)) begin
            fmax = b;
        end else begin
            fmax = a;
        end
    endfunction

    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [BUS_W-1:0]  h_q, h_d;
    logic [BUS_W-1:0]  out_q, out_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;

    logic              col_last;
    logic              row_last;
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [BUS_W-1:0]  pair;
    logic [BUS_W-1:0]  rd_word;
    logic [BUS_W-1:0]  pool_out;

    // One entry per output column; holds the even-row pair maxima. Not reset:
    // every entry is rewritten on an even row before an odd row reads it.
    logic [BUS_W-1:0]  line_mem [OUT_W];

    assign col_last = (col_q == COL_W'(IN_WIDTH - 1));
    assign row_last = (row_q == ROW_W'(IN_HEIGHT - 1));

    // Odd column completes a horizontal pair. Odd columns never fall in an
    // odd trailing column, and odd rows never in an odd trailing row, so the
    // trailing pixels produce no output without extra gating.
    assign wr_en = Valid_In && col_q[0] && !row_q[0];
    assign rd_en = Valid_In && col_q[0] && row_q[0];
    assign addr  = ADDR_W'(col_q >> 1);

    assign rd_word = line_mem[addr];

    always_comb begin
        pair     = '0;
        pool_out = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            pair[k*DATA_WIDHT +: DATA_WIDHT] =
                fmax(h_q[k*DATA_WIDHT +: DATA_WIDHT], Data_In[k*DATA_WIDHT +: DATA_WIDHT]);
            pool_out[k*DATA_WIDHT +: DATA_WIDHT] =
                fmax(rd_word[k*DATA_WIDHT +: DATA_WIDHT], pair[k*DATA_WIDHT +: DATA_WIDHT]);
        end
    end

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        h_d     = h_q;
        out_d   = out_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        if (Valid_In) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            if (!col_q[0]) begin
                h_d = Data_In;
            end
            if (rd_en) begin
                out_d   = pool_out;
                valid_d = 1'b1;
                done_d  = (row_q == ROW_W'(2 * OUT_H - 1)) && (col_q == COL_W'(2 * OUT_W - 1));
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q   <= '0;
            row_q   <= '0;
            h_q     <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            h_q     <= h_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_mem[addr] <= pair;
        end
    end

    assign Data_Out   = out_q;
    assign Valid_Out  = valid_q;
    assign Frame_Done = done_q;

endmodule

// File: tb/tb_maxpool2d_2x2_stride2.sv
// tb/tb_maxpool2d_2x2_stride2.sv - scoreboard bench for maxpool2d_2x2_stride2

module tb_maxpool2d_2x2_stride2;

    typedef struct {
        logic [255:0] data;
        logic         fd;
        int           cyc;
    } sb_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    int           cyc = 0;
    int           n_cmp = 0;
    int           n_bad = 0;

    logic [63:0]  din_a = '0, din_b = '0;
    logic [255:0] din_c = '0;
    logic         vin_a = 1'b0, vin_b = 1'b0, vin_c = 1'b0;
    logic [63:0]  do_a, do_b;
    logic [255:0] do_c;
    logic         vo_a, vo_b, vo_c, fd_a, fd_b, fd_c;

    sb_t          q_a[$], q_b[$], q_c[$];
    sb_t          it_a, it_b, it_c;
    logic [255:0] last_a = '0, last_b = '0, last_c = '0;
    logic [63:0]  exp4 [4];
    logic [63:0]  exp5 [4];
    logic [255:0] frame_c [218*218];
    logic [255:0] line_m  [109];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    maxpool2d_2x2_stride2 #(.DATA_WIDHT(32), .CHANNELS(2), .IN_WIDTH(4), .IN_HEIGHT(4)) dut_a (
        .clk(clk), .rst(rst), .Data_In(din_a), .Valid_In(vin_a),
        .Data_Out(do_a), .Valid_Out(vo_a), .Frame_Done(fd_a));

    maxpool2d_2x2_stride2 #(.DATA_WIDHT(32), .CHANNELS(2), .IN_WIDTH(5), .IN_HEIGHT(5)) dut_b (
        .clk(clk), .rst(rst), .Data_In(din_b), .Valid_In(vin_b),
        .Data_Out(do_b), .Valid_Out(vo_b), .Frame_Done(fd_b));

    maxpool2d_2x2_stride2 dut_c (
        .clk(clk), .rst(rst), .Data_In(din_c), .Valid_In(vin_c),
        .Data_Out(do_c), .Valid_Out(vo_c), .Frame_Done(fd_c));

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_max(input logic [31:0] a, input logic [31:0] b);
        bit b_wins;
        if (a[30:0] == 0 && b[30:0] == 0) b_wins = 1'b0;
        else if (a[31] != b[31])          b_wins = a[31];
        else if (!a[31])                  b_wins = b[30:0] > a[30:0];
        else                              b_wins = b[30:0] < a[30:0];
        return b_wins ? b : a;
    endfunction

    function automatic logic [255:0] ref_maxv(input logic [255:0] a, input logic [255:0] b);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = ref_max(a[k*32 +: 32], b[k*32 +: 32]);
        return r;
    endfunction

    // Small non-negative integer n as fp32 bits, optionally negated.
    function automatic logic [31:0] int2f(input int n, input bit neg);
        logic [31:0] f;
        logic [31:0] m;
        int          e;
        f = '0;
        if (n != 0) begin
            e = 0;
            for (int i = 0; i < 31; i++) if ((n >> i) != 0) e = i;
            m = n << (23 - e);
            f[30:23] = 8'(127 + e);
            f[22:0]  = m[22:0];
        end
        f[31] = neg;
        return f;
    endfunction

    task automatic beat(input int s, input logic [255:0] d, input bit trig,
                        input logic [255:0] e, input bit fd);
        sb_t it;
        @(negedge clk);
        it.data = e;
        it.fd   = fd;
        it.cyc  = cyc + 1;
        case (s)
            0: begin din_a = d[63:0]; vin_a = 1'b1; if (trig) q_a.push_back(it); end
            1: begin din_b = d[63:0]; vin_b = 1'b1; if (trig) q_b.push_back(it); end
            default: begin din_c = d; vin_c = 1'b1; if (trig) q_c.push_back(it); end
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            vin_a = 1'b0; vin_b = 1'b0; vin_c = 1'b0;
        end
    endtask

    task automatic ramp(input int s, input int w, input int h, input bit gaps, input int nmax);
        int           n, idx;
        bit           trig;
        logic [63:0]  d, e;
        n = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (n < nmax) begin
                    d    = {int2f(w*r + c, 1'b1), int2f(w*r + c, 1'b0)};
                    trig = (r % 2 == 1) && (c % 2 == 1);
                    idx  = trig ? (r/2)*(w/2) + c/2 : 0;
                    e    = (w == 4) ? exp4[idx] : exp5[idx];
                    beat(s, {192'b0, d}, trig, {192'b0, e}, trig && idx == (w/2)*(h/2) - 1);
                    if (gaps) idle($urandom_range(0, 3));
                end
                n++;
            end
        end
    endtask

    task automatic chk_rst();
        chk("rst_vo_a", vo_a, 0); chk("rst_fd_a", fd_a, 0); chk("rst_do_a", do_a, 0);
        chk("rst_vo_b", vo_b, 0); chk("rst_fd_b", fd_b, 0); chk("rst_do_b", do_b, 0);
        chk("rst_vo_c", vo_c, 0); chk("rst_fd_c", fd_c, 0); chk("rst_do_c", do_c, 0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (vo_a) begin
                if (q_a.size() == 0) chk("a_extra_valid", vo_a, 0);
                else begin
                    it_a = q_a.pop_front();
                    chk("a_data", {192'b0, do_a}, it_a.data);
                    chk("a_frame_done", fd_a, it_a.fd);
                    chk("a_latency", cyc, it_a.cyc);
                end
            end else begin
                chk("a_fd_idle", fd_a, 0);
                chk("a_hold", do_a, last_a);
            end
        end
        last_a = {192'b0, do_a};
    end

    always @(negedge clk) begin
        if (rst) begin
            if (vo_b) begin
                if (q_b.size() == 0) chk("b_extra_valid", vo_b, 0);
                else begin
                    it_b = q_b.pop_front();
                    chk("b_data", {192'b0, do_b}, it_b.data);
                    chk("b_frame_done", fd_b, it_b.fd);
                    chk("b_latency", cyc, it_b.cyc);
                end
            end else begin
                chk("b_fd_idle", fd_b, 0);
                chk("b_hold", do_b, last_b);
            end
        end
        last_b = {192'b0, do_b};
    end

    always @(negedge clk) begin
        if (rst) begin
            if (vo_c) begin
                if (q_c.size() == 0) chk("c_extra_valid", vo_c, 0);
                else begin
                    it_c = q_c.pop_front();
                    chk("c_data", do_c, it_c.data);
                    chk("c_frame_done", fd_c, it_c.fd);
                    chk("c_latency", cyc, it_c.cyc);
                end
            end else begin
                chk("c_fd_idle", fd_c, 0);
                chk("c_hold", do_c, last_c);
            end
        end
        last_c = do_c;
    end

    initial begin
        logic [31:0]  p0, p1, w;
        logic [255:0] d, hp, pr, e;
        int           idx;
        bit           trig;

        exp4[0] = {32'h80000000, 32'h40A00000};
        exp4[1] = {32'hC0000000, 32'h40E00000};
        exp4[2] = {32'hC1000000, 32'h41500000};
        exp4[3] = {32'hC1200000, 32'h41700000};
        exp5[0] = {32'h80000000, 32'h40C00000};
        exp5[1] = {32'hC0000000, 32'h41000000};
        exp5[2] = {32'hC1200000, 32'h41800000};
        exp5[3] = {32'hC1400000, 32'h41900000};

        // Reset with Valid_In active: beats must be ignored.
        vin_a = 1'b1; din_a = 64'h3F800000_3F800000;
        vin_b = 1'b1; din_b = 64'h40000000_40000000;
        repeat (3) @(negedge clk);
        chk_rst();
        rst = 1'b1; vin_a = 1'b0; vin_b = 1'b0;
        idle(2);

        ramp(0, 4, 4, 1'b0, 16);
        idle(3);
        ramp(0, 4, 4, 1'b1, 16);
        idle(3);

        // Sign/zero window at (0,0); every other pixel is 1.0.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                p0 = 32'h3F800000; p1 = 32'h3F800000;
                if (r == 0 && c == 0) begin p0 = 32'hBF800000; p1 = 32'hC0400000; end
                if (r == 0 && c == 1) begin p0 = 32'h00000000; p1 = 32'h80000000; end
                if (r == 1 && c == 0) begin p0 = 32'h80000000; p1 = 32'h00000000; end
                if (r == 1 && c == 1) begin p0 = 32'hC0400000; p1 = 32'hBF800000; end
                trig = (r % 2 == 1) && (c % 2 == 1);
                idx  = (r/2)*2 + c/2;
                e    = (idx == 0) ? {192'b0, 32'h80000000, 32'h00000000}
                                  : {192'b0, 32'h3F800000, 32'h3F800000};
                beat(0, {192'b0, p1, p0}, trig, e, trig && idx == 3);
            end
        end
        idle(3);

        ramp(1, 5, 5, 1'b0, 25);
        ramp(1, 5, 5, 1'b0, 25);
        idle(3);

        // Abort a frame after six beats (the sixth completes window 0).
        ramp(0, 4, 4, 1'b0, 6);
        idle(2);
        @(negedge clk);
        rst = 1'b0; vin_a = 1'b1; din_a = 64'hDEADBEEF_12345678;
        @(negedge clk);
        chk_rst();
        @(negedge clk);
        rst = 1'b1; vin_a = 1'b0;
        idle(2);
        ramp(0, 4, 4, 1'b0, 16);
        idle(3);

        // Default-size frame of random words, with some signed zeros mixed in.
        for (int i = 0; i < 218*218; i++) begin
            for (int k = 0; k < 8; k++) begin
                w = $urandom;
                if (w[3:0] == 4'd0) w = {w[31], 31'b0};
                frame_c[i][k*32 +: 32] = w;
            end
        end
        hp = '0;
        for (int r = 0; r < 218; r++) begin
            for (int c = 0; c < 218; c++) begin
                d    = frame_c[r*218 + c];
                trig = 1'b0;
                e    = '0;
                if (c % 2 == 0) hp = d;
                else begin
                    pr = ref_maxv(hp, d);
                    if (r % 2 == 0) line_m[c/2] = pr;
                    else begin
                        trig = 1'b1;
                        e    = ref_maxv(line_m[c/2], pr);
                    end
                end
                beat(2, d, trig, e, trig && r == 217 && c == 217);
            end
        end
        idle(5);

        chk("a_pending", q_a.size(), 0);
        chk("b_pending", q_b.size(), 0);
        chk("c_pending", q_c.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
